countdown_mmss: RTL and testbench

// - Two-digit-BCD minute:second countdown timer; downstream consumer of the push-button setting counters.
// - Loads the preset MM:SS from the setting stage, counts down once per 1 Hz tick and flags completion.
// - Outputs feed the 7-segment scan/display stage directly as packed BCD.

---
 rtl/countdown_mmss_pkg.sv | 15 +
 rtl/countdown_mmss_bcd2_down.sv | 29 ++
 rtl/countdown_mmss.sv | 66 ++++++
 tb/tb_countdown_mmss.sv | 125 ++++++++++++
 4 files changed

// File: rtl/countdown_mmss_pkg.sv
// countdown_mmss_pkg: shared state encoding, BCD constants and digit clamp helper
package countdown_mmss_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;
  localparam logic [7:0] BCD_ZERO      = 8'h00;
  localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;
  function automatic logic [7:0] clamp_digits(input logic [7:0] v);
    return {(v[7:4] > BCD_DIGIT_MAX) ? BCD_DIGIT_MAX : v[7:4],
            (v[3:0] > BCD_DIGIT_MAX) ? BCD_DIGIT_MAX : v[3:0]};
  endfunction
endpackage

// File: rtl/countdown_mmss_bcd2_down.sv
// countdown_mmss_bcd2_down: two-digit BCD down counter with reload on borrow
module countdown_mmss_bcd2_down
  import countdown_mmss_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       dec,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic [7:0] reload_val,
  output logic [7:0] val,
  output logic       borrow_out
);
  logic [7:0] val_d, val_q;
  // load has priority; a decrement at 00 wraps to reload_val and borrows
  always_comb begin
    val_d      = load ? load_val :
                 !dec ? val_q :
                 (val_q == BCD_ZERO) ? reload_val :
                 (val_q[3:0] != 4'd0) ? {val_q[7:4], val_q[3:0] - 4'd1} :
                 {val_q[7:4] - 4'd1, BCD_DIGIT_MAX};
    borrow_out = dec && (val_q == BCD_ZERO);
  end
  // count register
  always_ff @(posedge clk or posedge rst)
    if (rst) val_q <= BCD_ZERO;
    else     val_q <= val_d;
  assign val = val_q;
endmodule

// File: rtl/countdown_mmss.sv
// countdown_mmss: BCD MM:SS countdown timer with run/pause/done control
module countdown_mmss
  import countdown_mmss_pkg::*;
#(
  parameter logic [7:0] SEC_MAX = 8'h59,
  parameter logic [7:0] MIN_MAX = 8'h59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       load,
  input  logic       start_stop,
  input  logic [7:0] load_sec,
  input  logic [7:0] load_min,
  output logic [7:0] sec,
  output logic [7:0] min,
  output logic       running,
  output logic       done,
  output logic       done_pulse
);
  state_t     state_d, state_q;
  logic       done_pulse_d, done_pulse_q;
  logic       run_tick, load_en, sec_borrow, min_borrow, count_zero, last_tick;
  logic [7:0] sec_clamp, min_clamp, sec_dig, min_dig;
  assign sec_dig   = clamp_digits(load_sec);
  assign min_dig   = clamp_digits(load_min);
  assign sec_clamp = (sec_dig > SEC_MAX) ? SEC_MAX : sec_dig;
  assign min_clamp = (min_dig > MIN_MAX) ? MIN_MAX : min_dig;
  assign run_tick  = tick && (state_q == ST_RUN);
  assign load_en   = load && (state_q != ST_RUN);
  assign count_zero = (sec == BCD_ZERO) && (min == BCD_ZERO);
  assign last_tick  = run_tick && (sec == 8'h01) && (min == BCD_ZERO);
  countdown_mmss_bcd2_down u_sec (
    .clk(clk), .rst(rst), .dec(run_tick), .load(load_en),
    .load_val(sec_clamp), .reload_val(SEC_MAX), .val(sec), .borrow_out(sec_borrow)
  );
  countdown_mmss_bcd2_down u_min (
    .clk(clk), .rst(rst), .dec(sec_borrow), .load(load_en),
    .load_val(min_clamp), .reload_val(BCD_ZERO), .val(min), .borrow_out(min_borrow)
  );
  // next state: load beats start_stop outside RUN, reaching 00:00 beats pause
  always_comb begin
    state_d      = state_q;
    done_pulse_d = 1'b0;
    if (load_en) state_d = ST_IDLE;
    else if (last_tick) begin
      state_d      = ST_DONE;
      done_pulse_d = 1'b1;
    end else if (start_stop)
      state_d = (state_q == ST_IDLE)  ? (count_zero ? ST_IDLE : ST_RUN) :
                (state_q == ST_RUN)   ? ST_PAUSE :
                (state_q == ST_PAUSE) ? ST_RUN : ST_IDLE;
  end
  // state and completion pulse registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q      <= ST_IDLE;
      done_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      done_pulse_q <= done_pulse_d;
    end
  assign running    = (state_q == ST_RUN);
  assign done       = (state_q == ST_DONE);
  assign done_pulse = done_pulse_q;
endmodule

// File: tb/tb_countdown_mmss.sv
// tb_countdown_mmss: directed self-checking bench for the MM:SS countdown timer
module tb_countdown_mmss;
  logic       clk = 1'b0, rst = 1'b1;
  logic       tick = 1'b0, load = 1'b0, start_stop = 1'b0;
  logic [7:0] load_sec = 8'h00, load_min = 8'h00;
  logic [7:0] sec, min;
  logic       running, done, done_pulse;
  int         n_pass = 0, n_total = 0;

  countdown_mmss dut (
    .clk(clk), .rst(rst), .tick(tick), .load(load), .start_stop(start_stop),
    .load_sec(load_sec), .load_min(load_min), .sec(sec), .min(min),
    .running(running), .done(done), .done_pulse(done_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step(input logic t, input logic l, input logic s,
                      input logic [7:0] ls = 8'h00, input logic [7:0] lm = 8'h00);
    @(negedge clk);
    tick = t; load = l; start_stop = s; load_sec = ls; load_min = lm;
    @(posedge clk);
    #1;
    tick = 1'b0; load = 1'b0; start_stop = 1'b0;
  endtask

  task automatic check_st(input string tag, input logic [15:0] mmss,
                          input logic r, input logic d, input logic p);
    check({tag, "_mmss"}, {min, sec}, mmss);
    check({tag, "_run"}, {15'd0, running}, {15'd0, r});
    check({tag, "_done"}, {15'd0, done}, {15'd0, d});
    check({tag, "_dp"}, {15'd0, done_pulse}, {15'd0, p});
  endtask

  initial begin
    logic [15:0] exp_seq [6];
    exp_seq = '{16'h0104, 16'h0103, 16'h0102, 16'h0101, 16'h0100, 16'h0059};
    #2;
    check_st("reset", 16'h0000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    // start at 00:00 is ignored
    step(0, 0, 1);
    check_st("start_zero", 16'h0000, 1'b0, 1'b0, 1'b0);
    // load 01:05, run six ticks across a minute borrow
    step(0, 1, 0, 8'h05, 8'h01);
    check_st("load_0105", 16'h0105, 1'b0, 1'b0, 1'b0);
    step(0, 0, 1);
    check_st("start_0105", 16'h0105, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step(1, 0, 0);
      check_st($sformatf("tick%0d", i), exp_seq[i], 1'b1, 1'b0, 1'b0);
    end
    // non-tick cycle in RUN holds
    step(0, 0, 0);
    check_st("hold_run", 16'h0059, 1'b1, 1'b0, 1'b0);
    // pause, then load 00:02 returns to IDLE
    step(0, 0, 1);
    check_st("pause", 16'h0059, 1'b0, 1'b0, 1'b0);
    step(1, 0, 0);
    check_st("pause_tick", 16'h0059, 1'b0, 1'b0, 1'b0);
    step(0, 1, 0, 8'h02, 8'h00);
    check_st("load_0002", 16'h0002, 1'b0, 1'b0, 1'b0);
    step(0, 0, 1);
    step(1, 0, 0);
    check_st("t_0001", 16'h0001, 1'b1, 1'b0, 1'b0);
    step(1, 0, 0);
    check_st("t_0000", 16'h0000, 1'b0, 1'b1, 1'b1);
    step(0, 0, 0);
    check_st("done_hold", 16'h0000, 1'b0, 1'b1, 1'b0);
    step(1, 0, 0);
    check_st("done_tick", 16'h0000, 1'b0, 1'b1, 1'b0);
    // clamp: sec 60 -> 59, min 7A -> 79 -> 59
    step(0, 1, 0, 8'h60, 8'h7A);
    check_st("clamp_5959", 16'h5959, 1'b0, 1'b0, 1'b0);
    step(0, 1, 0, 8'h3F, 8'hA2);
    check_st("clamp_digit", 16'h5939, 1'b0, 1'b0, 1'b0);
    // load + start_stop in IDLE: load wins, stays IDLE
    step(0, 1, 1, 8'h10, 8'h00);
    check_st("load_start", 16'h0010, 1'b0, 1'b0, 1'b0);
    // tick + start_stop in RUN at 00:10 -> 00:09 paused
    step(0, 0, 1);
    check_st("run_0010", 16'h0010, 1'b1, 1'b0, 1'b0);
    step(1, 0, 1);
    check_st("tick_pause", 16'h0009, 1'b0, 1'b0, 1'b0);
    step(1, 0, 0);
    check_st("paused_tick", 16'h0009, 1'b0, 1'b0, 1'b0);
    step(0, 0, 1);
    check_st("resume", 16'h0009, 1'b1, 1'b0, 1'b0);
    // tick + start_stop at 00:01: DONE beats PAUSE
    step(0, 0, 1);
    step(0, 1, 0, 8'h01, 8'h00);
    step(0, 0, 1);
    check_st("run_0001", 16'h0001, 1'b1, 1'b0, 1'b0);
    step(1, 0, 1);
    check_st("done_wins", 16'h0000, 1'b0, 1'b1, 1'b1);
    step(0, 0, 1);
    check_st("ack_idle", 16'h0000, 1'b0, 1'b0, 1'b0);
    step(0, 0, 1);
    check_st("ack_again", 16'h0000, 1'b0, 1'b0, 1'b0);
    // RUN at 12:34: load ignored, async reset mid-cycle
    step(0, 1, 0, 8'h34, 8'h12);
    step(0, 0, 1);
    check_st("run_1234", 16'h1234, 1'b1, 1'b0, 1'b0);
    step(0, 1, 0, 8'h05, 8'h00);
    check_st("run_load_ign", 16'h1234, 1'b1, 1'b0, 1'b0);
    step(1, 0, 0);
    check_st("t_1233", 16'h1233, 1'b1, 1'b0, 1'b0);
    #1 rst = 1'b1;
    #1;
    check_st("async_rst", 16'h0000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    step(1, 0, 0);
    check_st("post_rst", 16'h0000, 1'b0, 1'b0, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
